adder_seq16: RTL and testbench
==============================

Name: adder_seq16

Overview:
- Multi-cycle WIDTH-bit adder built around one 4-bit ripple slice, the existing `adder4`.
- Sits directly upstream of `adder4`: captures operands, feeds the slice one nibble per cycle LSB-first, and chains the carry through a register.
- Assembles the sum and returns it over a valid/ready handshake.
- Trades latency for area in the FPGA adder lab designs.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived slice count; not overridable.

Ports:
- Clk  input  1  system clock; all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum.
- cout  output  1  final carry-out.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock (Clk); reset Reset_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, S=0, cout=0, ovf=0; nibble counter=0; operand and carry registers cleared.
- FSM has three states.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and cin, clear the counter, go to RUN.
  - RUN: in_ready=0. Each cycle, slice k=counter gets A[4k+3:4k], B[4k+3:4k] and the carry register.
    - Write the slice sum into S[4k+3:4k]; register the slice carry-out.
    - On k=NIBBLES-1, also capture cout and ovf, then go to DONE. Otherwise increment the counter.
    - ovf needs the carry into the MSB, i.e. bit 2 of the last slice's internal carry. Compute it as A[MSB]^B[MSB]^S[MSB], XORed with the slice carry-out.
  - DONE: out_valid=1, and S/cout/ovf held stable. On out_valid&&out_ready, out_valid drops next edge and the FSM returns to IDLE.
- Latency: handshake edge at cycle 0, then NIBBLES RUN cycles. out_valid rises on the edge ending cycle NIBBLES (5th edge for WIDTH=16).
- Throughput: one add per NIBBLES+2 cycles (no IDLE/DONE overlap); in_ready is combinational from state only.
- Boundary conditions:
  - in_valid asserted in RUN/DONE is ignored; no operand overwrite.
  - out_ready held low keeps the FSM in DONE indefinitely, with outputs unchanged.
  - out_ready high before DONE has no effect.
  - Wrap-around: the sum is modulo 2^WIDTH and the carry is reported only on cout.
  - Reset_n low at any point, including mid-RUN, returns the FSM to reset values asynchronously; the partial sum is discarded.
  - S is updated nibble-by-nibble during RUN and is valid only while out_valid=1.

Optional Feature:
- Macro ADDER_SEQ_SUB_EN.
  - Defined: adds input port `sub` (1 bit), latched with the operands. When sub=1, B is captured inverted and the initial carry is forced to 1 (A−B), ignoring cin. cout=1 means no borrow; ovf is signed subtract overflow.
  - Undefined: no `sub` port; addition only; cin used as given.

Decomposition:
- Package `adder_seq_pkg`: state enum (IDLE, RUN, DONE) and the SLICE_W=4 constant.
- Sub-module: instantiate the existing `adder4` once as the datapath slice. The controller/registers stay in adder_seq16; no other sub-modules.

Test Plan:
- A=0x1234, B=0x4321, cin=0 -> S=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the handshake edge.
- A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1, ovf=0 (carry ripples through all nibbles).
- A=0x7FFF, B=0x0001, cin=0 -> S=0x8000, cout=0, ovf=1; A=0x8000, B=0x8000 -> S=0x0000, cout=1, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE, driving in_valid with A=0x1111 -> result unchanged, in_ready=0. Then out_ready=1 -> IDLE, and the next add produces the new result.
- Pulse Reset_n low during the 2nd RUN cycle of 0xABCD+0x1111 -> all outputs immediately reset values, in_ready=1. A subsequent 0x0001+0x0001 gives 0x0002.
- With ADDER_SEQ_SUB_EN: A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, cout=0, ovf=0; A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, ovf=1.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry slice: one full adder per bit, carry chained LSB to MSB.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c_s;

    // Ripple the carry through the four bit positions.
    always_comb begin
        c_s    = 5'd0;
        s      = 4'd0;
        c_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
        cout = c_s[4];
    end

endmodule

// File: rtl/adder_seq16.sv
// Multi-cycle WIDTH-bit adder feeding one adder4 slice a nibble per cycle, LSB first.
// Optional subtract mode (sub port, B inverted, carry-in forced to 1) under `ADDER_SEQ_SUB_EN.
module adder_seq16
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [CNT_W+1:0]   sh_s;
    logic [WIDTH-1:0]   a_shift_s, b_shift_s, mask_s;
    logic [SLICE_W-1:0] slice_a_s, slice_b_s, slice_s_s;
    logic               slice_cout_s;
    logic               last_s;

    // Nibble select: the counter times four is the bit offset of the active slice.
    always_comb begin
        sh_s      = {cnt_q, 2'b00};
        a_shift_s = a_q >> sh_s;
        b_shift_s = b_q >> sh_s;
        slice_a_s = a_shift_s[SLICE_W-1:0];
        slice_b_s = b_shift_s[SLICE_W-1:0];
        mask_s    = WIDTH'(4'hF) << sh_s;
        last_s    = (cnt_q == CNT_W'(NIBBLES - 1));
    end

    adder4 u_slice (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_q),
        .s    (slice_s_s),
        .cout (slice_cout_s)
    );

    // Next-state and datapath register update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
`ifdef ADDER_SEQ_SUB_EN
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = B;
                    carry_d = cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d     = (s_q & ~mask_s) | (WIDTH'(slice_s_s) << sh_s);
                carry_d = slice_cout_s;
                if (last_s) begin
                    cout_d      = slice_cout_s;
                    // Carry into the MSB recovered from the MSB sum bit.
                    ovf_d       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s_s[SLICE_W-1] ^ slice_cout_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_seq16.sv
// Self-checking bench for adder_seq16: directed corner cases plus random adds vs. an arithmetic model.
module tb_adder_seq16;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic         Clk;
    logic         Reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;

    int tests;
    int fails;

    adder_seq16 #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic sb,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ci;
        be   = sb ? ~b : b;
        ci   = sb ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // One transaction: handshake, wait for result with a bound, check, then consume.
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic sb, input bit noisy);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        bit           got;
        model(a, b, c, sb, es, ec, eo);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready) got = 1'b1;
            else begin @(posedge Clk); #1; end
        end
        check({tag, " in_ready_wait"}, {31'd0, got}, 32'd1);
        A = a; B = b; cin = c; sub = sb; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check({tag, " in_ready_run"}, {31'd0, in_ready}, 32'd0);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (noisy && i < NIBBLES) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                A = W'($urandom); B = W'($urandom); cin = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b0;
                in_valid  = 1'b0;
            end
            @(posedge Clk); #1;
            if (out_valid) begin got = 1'b1; lat = i; end
        end
        in_valid = 1'b0;
        check({tag, " done_timeout"}, {31'd0, got}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(NIBBLES));
        @(negedge Clk);
        check({tag, " S"}, {16'd0, S}, {16'd0, es});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc, ho;
        int           lat;
        bit           got;
        tests = 0; fails = 0;
        Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        #23;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst S", {16'd0, S}, 32'd0);
        check("rst cout", {31'd0, cout}, 32'd0);
        check("rst ovf", {31'd0, ovf}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        do_add("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_add("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_add("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        do_add("cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 1'b1);

        // Back-pressure: result must hold in DONE while new operands are offered.
        model(16'h0F0F, 16'h1010, 1'b0, 1'b0, hs, hc, ho);
        A = 16'h0F0F; B = 16'h1010; cin = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge Clk); #1;
            if (out_valid) got = 1'b1;
        end
        check("hold reach_done", {31'd0, got}, 32'd1);
        A = 16'h1111; B = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
        end
        check("hold S", {16'd0, S}, {16'd0, hs});
        check("hold cout", {31'd0, cout}, {31'd0, hc});
        check("hold out_valid", {31'd0, out_valid}, 32'd1);
        check("hold in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check("hold release", {31'd0, in_ready}, 32'd1);
        do_add("after_hold", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the second RUN cycle discards the partial sum.
        A = 16'hABCD; B = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check("midrst S", {16'd0, S}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst cout", {31'd0, cout}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        do_add("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_add("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef ADDER_SEQ_SUB_EN
        do_add("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        do_add("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            do_add("rand_sub", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
`endif

        lat = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
